// File: rtl/nearest_free_alloc_pkg.sv
// Shared constants and types for the nearest-free entry allocator.
package nearest_free_alloc_pkg;

  localparam int DEFAULT_VECTOR_WIDTH = 32;

  // Response slot occupancy
  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

endpackage

// File: rtl/nearest_index.sv
// Combinational nearest-set-bit finder with modular distance around a target index.
// At equal distance the entry above the target (target+d) wins over target-d.
module nearest_index #(
  parameter int VECTOR_WIDTH = 32,
  parameter int INDEX_WIDTH  = $clog2(VECTOR_WIDTH)
) (
  input  logic [VECTOR_WIDTH-1:0] bit_vector,
  input  logic [INDEX_WIDTH-1:0]  target_index,
  output logic                    bit_present,
  output logic [INDEX_WIDTH-1:0]  found_index
);

  assign bit_present = |bit_vector;

  // Walk distances from farthest to nearest so the nearest hit is written last;
  // within one distance the minus side is written first so the plus side overrides it.
  always_comb begin
    logic [INDEX_WIDTH-1:0] w_up;
    logic [INDEX_WIDTH-1:0] w_dn;
    w_up        = '0;
    w_dn        = '0;
    found_index = '0;
    for (int d = VECTOR_WIDTH / 2; d >= 0; d--) begin
      w_up = target_index + INDEX_WIDTH'(d);
      w_dn = target_index - INDEX_WIDTH'(d);
      if (bit_vector[w_dn]) found_index = w_dn;
      if (bit_vector[w_up]) found_index = w_up;
    end
  end

endmodule

// File: rtl/nearest_free_alloc.sv
// Entry allocator: hands out the free entry nearest a hint index through a
// one-deep registered response slot, and accepts returns of entries.
module nearest_free_alloc
  import nearest_free_alloc_pkg::*;
#(
  parameter int VECTOR_WIDTH = DEFAULT_VECTOR_WIDTH,
  parameter int INDEX_WIDTH  = $clog2(VECTOR_WIDTH)
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   alloc_req_valid,
  input  logic [INDEX_WIDTH-1:0] alloc_req_target,
  output logic                   alloc_req_ready,
  output logic                   alloc_resp_valid,
  output logic [INDEX_WIDTH-1:0] alloc_resp_index,
  input  logic                   alloc_resp_ready,
  input  logic                   dealloc_valid,
  input  logic [INDEX_WIDTH-1:0] dealloc_index,
  output logic                   dealloc_error,
  output logic [INDEX_WIDTH:0]   free_count
);

  slot_state_t             r_slot_state;
  slot_state_t             w_slot_next;
  logic [VECTOR_WIDTH-1:0] r_free_vec;
  logic [VECTOR_WIDTH-1:0] w_free_next;
  logic [INDEX_WIDTH:0]    r_free_count;
  logic [INDEX_WIDTH:0]    w_count_next;
  logic [INDEX_WIDTH-1:0]  r_resp_index;
  logic [INDEX_WIDTH-1:0]  w_sel_index;
  logic                    r_dealloc_error;
  logic                    w_bit_present;
  logic                    w_accept;
  logic                    w_dealloc_hit_free;
  logic                    w_dealloc_ok;

  nearest_index #(
    .VECTOR_WIDTH (VECTOR_WIDTH),
    .INDEX_WIDTH  (INDEX_WIDTH)
  ) u_select (
    .bit_vector   (r_free_vec),
    .target_index (alloc_req_target),
    .bit_present  (w_bit_present),
    .found_index  (w_sel_index)
  );

  // Ready depends only on registered state and the consumer; returns become visible a cycle later.
  assign alloc_req_ready    = ((r_slot_state == SLOT_EMPTY) || alloc_resp_ready) && w_bit_present;
  assign w_accept           = alloc_req_valid && alloc_req_ready;
  assign w_dealloc_hit_free = dealloc_valid && r_free_vec[dealloc_index];
  assign w_dealloc_ok       = dealloc_valid && !r_free_vec[dealloc_index];

  // Slot next-state: load on accept, drain when the consumer takes it without a refill.
  always_comb begin
    w_slot_next = r_slot_state;
    case (r_slot_state)
      SLOT_EMPTY: if (w_accept) w_slot_next = SLOT_FULL;
      SLOT_FULL: begin
        if (w_accept)              w_slot_next = SLOT_FULL;
        else if (alloc_resp_ready) w_slot_next = SLOT_EMPTY;
      end
      default:                     w_slot_next = SLOT_EMPTY;
    endcase
  end

  // Free-vector update; a valid return never targets a free entry, so it cannot collide with the selection.
  always_comb begin
    w_free_next = r_free_vec;
    if (w_dealloc_ok) w_free_next[dealloc_index] = 1'b1;
    if (w_accept)     w_free_next[w_sel_index]   = 1'b0;
  end

  assign w_count_next = r_free_count
                      + {{INDEX_WIDTH{1'b0}}, w_dealloc_ok}
                      - {{INDEX_WIDTH{1'b0}}, w_accept};

  // State registers with synchronous reset that discards any in-flight or held allocation.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_slot_state    <= SLOT_EMPTY;
      r_free_vec      <= '1;
      r_free_count    <= (INDEX_WIDTH+1)'(VECTOR_WIDTH);
      r_resp_index    <= '0;
      r_dealloc_error <= 1'b0;
    end else begin
      r_slot_state    <= w_slot_next;
      r_free_vec      <= w_free_next;
      r_free_count    <= w_count_next;
      r_dealloc_error <= w_dealloc_hit_free;
      if (w_accept) r_resp_index <= w_sel_index;
    end
  end

  assign alloc_resp_valid = (r_slot_state == SLOT_FULL);
  assign alloc_resp_index = r_resp_index;
  assign dealloc_error    = r_dealloc_error;
  assign free_count       = r_free_count;

endmodule

// File: tb/tb_nearest_free_alloc.sv
// Self-checking bench for nearest_free_alloc: directed table, corner sequences, random vs. model.
module tb_nearest_free_alloc;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       alloc_req_valid = 1'b0;
  logic [4:0] alloc_req_target = '0;
  logic       alloc_req_ready;
  logic       alloc_resp_valid;
  logic [4:0] alloc_resp_index;
  logic       alloc_resp_ready = 1'b0;
  logic       dealloc_valid = 1'b0;
  logic [4:0] dealloc_index = '0;
  logic       dealloc_error;
  logic [5:0] free_count;

  nearest_free_alloc #(.VECTOR_WIDTH(32), .INDEX_WIDTH(5)) dut (
    .CLK              (clk),
    .RST              (rst),
    .alloc_req_valid  (alloc_req_valid),
    .alloc_req_target (alloc_req_target),
    .alloc_req_ready  (alloc_req_ready),
    .alloc_resp_valid (alloc_resp_valid),
    .alloc_resp_index (alloc_resp_index),
    .alloc_resp_ready (alloc_resp_ready),
    .dealloc_valid    (dealloc_valid),
    .dealloc_index    (dealloc_index),
    .dealloc_error    (dealloc_error),
    .free_count       (free_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  bit [31:0] m_free = '1;
  bit        m_slot = 1'b0;
  int        m_idx = 0;
  bit        m_err = 1'b0;
  int        m_cnt = 32;
  bit        m_known = 1'b0;
  bit        s_ready;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Nearest free entry by modular distance; ties go to the entry above the target.
  function automatic int ref_nearest(input bit [31:0] fv, input int t);
    int best;
    int best_d;
    bit best_plus;
    best = -1;
    best_d = 99;
    best_plus = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if (fv[i]) begin
        int fwd;
        int bwd;
        int d;
        bit plus;
        fwd  = (i - t + 32) % 32;
        bwd  = (t - i + 32) % 32;
        d    = (fwd < bwd) ? fwd : bwd;
        plus = (fwd == d);
        if (d < best_d || (d == best_d && plus && !best_plus)) begin
          best = i;
          best_d = d;
          best_plus = plus;
        end
      end
    end
    return best;
  endfunction

  // One clock cycle: drive, check ready before the edge, update model, check outputs after.
  task automatic step(input bit r, input bit rv, input int tgt, input bit rr,
                      input bit dv, input int di);
    bit        exp_ready;
    bit        acc;
    int        sel;
    bit [31:0] nf;
    @(negedge clk);
    rst              = r;
    alloc_req_valid  = rv;
    alloc_req_target = 5'(tgt);
    alloc_resp_ready = rr;
    dealloc_valid    = dv;
    dealloc_index    = 5'(di);
    #1;
    s_ready   = alloc_req_ready;
    exp_ready = (!m_slot || rr) && (m_free != 0);
    if (m_known) chk("req_ready", int'(alloc_req_ready), int'(exp_ready));
    @(posedge clk);
    if (r) begin
      m_free = '1;
      m_slot = 1'b0;
      m_idx = 0;
      m_err = 1'b0;
      m_known = 1'b1;
    end else begin
      acc   = rv && exp_ready;
      sel   = ref_nearest(m_free, tgt);
      m_err = dv && m_free[di];
      nf    = m_free;
      if (dv && !m_free[di]) nf[di] = 1'b1;
      if (acc) nf[sel] = 1'b0;
      if (acc) begin
        m_slot = 1'b1;
        m_idx  = sel;
      end else if (rr) begin
        m_slot = 1'b0;
      end
      m_free = nf;
    end
    m_cnt = $countones(m_free);
    #1;
    chk("resp_valid", int'(alloc_resp_valid), int'(m_slot));
    if (m_slot) chk("resp_index", int'(alloc_resp_index), m_idx);
    chk("dealloc_error", int'(dealloc_error), int'(m_err));
    chk("free_count", int'(free_count), m_cnt);
  endtask

  typedef struct {
    bit rst;
    bit rv;
    int tgt;
    bit rr;
    bit dv;
    int di;
    bit e_ready;
    bit e_valid;
    int e_idx;
    int e_cnt;
    bit e_err;
  } vec_t;

  vec_t tv[10];

  initial begin
    //         rst rv tgt rr dv di   rdy val idx cnt err
    tv[0] = '{1'b1, 1'b0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 0, 32, 1'b0};
    tv[1] = '{1'b0, 1'b1, 5, 1'b1, 1'b0, 0, 1'b1, 1'b1, 5, 31, 1'b0};
    tv[2] = '{1'b0, 1'b1, 5, 1'b1, 1'b0, 0, 1'b1, 1'b1, 6, 30, 1'b0};
    tv[3] = '{1'b0, 1'b0, 0, 1'b1, 1'b1, 4, 1'b1, 1'b0, 6, 30, 1'b1};
    tv[4] = '{1'b0, 1'b0, 0, 1'b0, 1'b0, 0, 1'b1, 1'b0, 6, 30, 1'b0};
    tv[5] = '{1'b0, 1'b1, 4, 1'b0, 1'b1, 4, 1'b1, 1'b1, 4, 29, 1'b1};
    tv[6] = '{1'b0, 1'b1, 0, 1'b0, 1'b0, 0, 1'b0, 1'b1, 4, 29, 1'b0};
    tv[7] = '{1'b0, 1'b1, 5, 1'b1, 1'b1, 5, 1'b1, 1'b1, 7, 29, 1'b0};
    tv[8] = '{1'b0, 1'b1, 5, 1'b1, 1'b0, 0, 1'b1, 1'b1, 5, 28, 1'b0};
    tv[9] = '{1'b0, 1'b0, 0, 1'b1, 1'b0, 0, 1'b1, 1'b0, 5, 28, 1'b0};

    for (int k = 0; k < 10; k++) begin
      step(tv[k].rst, tv[k].rv, tv[k].tgt, tv[k].rr, tv[k].dv, tv[k].di);
      if (!tv[k].rst) chk("tbl_ready", int'(s_ready), int'(tv[k].e_ready));
      chk("tbl_valid", int'(alloc_resp_valid), int'(tv[k].e_valid));
      if (tv[k].e_valid || tv[k].rst) chk("tbl_index", int'(alloc_resp_index), tv[k].e_idx);
      chk("tbl_count", int'(free_count), tv[k].e_cnt);
      chk("tbl_error", int'(dealloc_error), int'(tv[k].e_err));
    end

    // exhaust the pool, then return one entry
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 32; i++) step(0, 1, i, 1, 0, 0);
    chk("full_count", int'(free_count), 0);
    step(0, 1, 0, 1, 0, 0);
    chk("full_ready", int'(s_ready), 0);
    step(0, 0, 0, 1, 1, 12);
    chk("no_bypass_ready", int'(s_ready), 0);
    step(0, 1, 0, 1, 0, 0);
    chk("refill_ready", int'(s_ready), 1);
    chk("refill_index", int'(alloc_resp_index), 12);
    // only 3 and 7 free, target 5: tie at distance 2 goes upward
    step(0, 0, 0, 1, 1, 3);
    step(0, 0, 0, 1, 1, 7);
    step(0, 1, 5, 1, 0, 0);
    chk("tie_index", int'(alloc_resp_index), 7);
    step(0, 1, 3, 1, 0, 0);
    chk("take3_index", int'(alloc_resp_index), 3);
    // only 0 and 30 free, target 31: wrap to 0
    step(0, 0, 0, 1, 1, 0);
    step(0, 0, 0, 1, 1, 30);
    step(0, 1, 31, 1, 0, 0);
    chk("wrap_index", int'(alloc_resp_index), 0);

    // held response under backpressure, then refill with same hint
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 9, 1, 0, 0);
    chk("hold_first", int'(alloc_resp_index), 9);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 0, 0, 0);
      chk("hold_ready", int'(s_ready), 0);
      chk("hold_index", int'(alloc_resp_index), 9);
    end
    step(0, 1, 9, 1, 0, 0);
    chk("reload_valid", int'(alloc_resp_valid), 1);
    chk("reload_index", int'(alloc_resp_index), 10);

    // reset while full with a request pending
    step(1, 1, 3, 0, 1, 9);
    chk("rst_valid", int'(alloc_resp_valid), 0);
    chk("rst_count", int'(free_count), 32);
    step(0, 0, 0, 0, 0, 0);
    chk("post_rst_ready", int'(s_ready), 1);

    // random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 199) == 0,
           $urandom_range(0, 9) < 7,
           int'($urandom_range(0, 31)),
           $urandom_range(0, 9) < 6,
           $urandom_range(0, 9) < 4,
           int'($urandom_range(0, 31)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
